// File: rtl/pm_sequencer_pkg.sv
// Shared types and constants for the phase-monitor sequencer.
// FSM state encoding and the sign-select codes driven onto sel_pm_sign.
package pm_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP_P,
        ST_MEAS_P,
        ST_SETTLE_P,
        ST_SETUP_N,
        ST_MEAS_N,
        ST_SETTLE_N,
        ST_DONE
    } pm_seq_state_t;

    localparam logic [1:0] PM_SIGN_OFF = 2'b00;
    localparam logic [1:0] PM_SIGN_POS = 2'b01;
    localparam logic [1:0] PM_SIGN_NEG = 2'b10;

endpackage

// File: rtl/pm_sequencer_if.sv
// Control/result bundle between the slice wrapper (master) and the sequencer (slave).
// pm_out is produced by the phase monitor and travels with the wrapper-side signals.
interface pm_sequencer_if #(
    parameter int Npm  = 20,
    parameter int Nwin = 16
) ();

    logic             start;
    logic [1:0]       cfg_sel_in;
    logic [Nwin-1:0]  win_len;
    logic [Npm-1:0]   pm_out;
    logic             en_pm;
    logic [1:0]       sel_pm_sign;
    logic [1:0]       sel_pm_in;
    logic             busy;
    logic             done;
    logic [Npm-1:0]   pm_pos;
    logic [Npm-1:0]   pm_neg;
    logic [Npm:0]     pm_diff;

    modport master (
        output start, cfg_sel_in, win_len, pm_out,
        input  en_pm, sel_pm_sign, sel_pm_in, busy, done, pm_pos, pm_neg, pm_diff
    );

    modport slave (
        input  start, cfg_sel_in, win_len, pm_out,
        output en_pm, sel_pm_sign, sel_pm_in, busy, done, pm_pos, pm_neg, pm_diff
    );

endinterface

// File: rtl/pm_sequencer.sv
// Phase-monitor sequencer: runs a positive and a negative measurement window,
// captures both counts and publishes them with their signed difference.
module pm_sequencer
    import pm_seq_pkg::*;
#(
    parameter int Npm     = 20,
    parameter int Nwin    = 16,
    parameter int Nsettle = 4
) (
    input  logic            clk,
    input  logic            rstb,
    pm_sequencer_if.slave   bus
);

    // One down-counter serves both the enable window and the settle wait.
    localparam int CntW = (Nwin > $clog2(Nsettle + 1)) ? Nwin : $clog2(Nsettle + 1);

    pm_seq_state_t    state;
    logic [CntW-1:0]  cnt;
    logic [Nwin-1:0]  win_q;
    logic [Npm-1:0]   pos_stage;

    // NOTE: every register, including the result outputs, is cleared by the
    // asynchronous reset so a mid-run abort leaves nothing stale on the ports.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            win_q           <= '0;
            pos_stage       <= '0;
            bus.en_pm       <= 1'b0;
            bus.sel_pm_sign <= PM_SIGN_OFF;
            bus.sel_pm_in   <= 2'b00;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.pm_pos      <= '0;
            bus.pm_neg      <= '0;
            bus.pm_diff     <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; outputs are computed
            // for the state being entered so they are registered, not decoded.
            bus.done <= 1'b0;
            unique case (state)
                // DONE samples start like IDLE so a held start runs back-to-back.
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        win_q           <= (bus.win_len == '0) ? Nwin'(1) : bus.win_len;
                        bus.sel_pm_in   <= bus.cfg_sel_in;
                        bus.sel_pm_sign <= PM_SIGN_POS;
                        bus.busy        <= 1'b1;
                        state           <= ST_SETUP_P;
                    end else begin
                        bus.sel_pm_sign <= PM_SIGN_OFF;
                        bus.busy        <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                ST_SETUP_P: begin
                    bus.en_pm <= 1'b1;
                    cnt       <= CntW'(win_q) - CntW'(1);
                    state     <= ST_MEAS_P;
                end
                ST_MEAS_P: begin
                    if (cnt == '0) begin
                        bus.en_pm <= 1'b0;
                        cnt       <= CntW'(Nsettle - 1);
                        state     <= ST_SETTLE_P;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                ST_SETTLE_P: begin
                    if (cnt == '0) begin
                        pos_stage       <= bus.pm_out;
                        bus.sel_pm_sign <= PM_SIGN_NEG;
                        state           <= ST_SETUP_N;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                ST_SETUP_N: begin
                    bus.en_pm <= 1'b1;
                    cnt       <= CntW'(win_q) - CntW'(1);
                    state     <= ST_MEAS_N;
                end
                ST_MEAS_N: begin
                    if (cnt == '0) begin
                        bus.en_pm <= 1'b0;
                        cnt       <= CntW'(Nsettle - 1);
                        state     <= ST_SETTLE_N;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                ST_SETTLE_N: begin
                    if (cnt == '0) begin
                        // All three results land on the same edge.
                        bus.pm_pos      <= pos_stage;
                        bus.pm_neg      <= bus.pm_out;
                        bus.pm_diff     <= {1'b0, pos_stage} - {1'b0, bus.pm_out};
                        bus.done        <= 1'b1;
                        bus.sel_pm_sign <= PM_SIGN_OFF;
                        state           <= ST_DONE;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pm_sequencer.sv
// Scoreboard bench for pm_sequencer: a driver issues runs and queues expected
// results, a phase-monitor model supplies pm_out, a monitor checks on done.
module tb_pm_sequencer;
    import pm_seq_pkg::*;

    localparam int NPM  = 20;
    localparam int NWIN = 16;
    localparam int NSET = 4;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    pm_sequencer_if #(.Npm(NPM), .Nwin(NWIN)) bus ();

    pm_sequencer #(.Npm(NPM), .Nwin(NWIN), .Nsettle(NSET)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    typedef struct {
        int     pos;
        int     neg;
        int     w;
        int     sel;
        longint done_cyc;
    } exp_t;

    typedef struct {
        int pos;
        int neg;
    } pmv_t;

    exp_t   exp_q[$];
    pmv_t   pmv_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, longint act, longint expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Phase monitor: counts while enabled, then holds the scripted count for the selected sign.
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (!rstb) begin
            bus.pm_out = '0;
            prev_en    = 1'b0;
        end else if (bus.en_pm) begin
            bus.pm_out = prev_en ? bus.pm_out + 1'b1 : '0;
            prev_en    = 1'b1;
        end else if (prev_en) begin
            prev_en = 1'b0;
            if (pmv_q.size() == 0)
                bus.pm_out = 20'h0BAD0;
            else if (bus.sel_pm_sign == PM_SIGN_POS)
                bus.pm_out = NPM'(pmv_q[0].pos);
            else if (bus.sel_pm_sign == PM_SIGN_NEG) begin
                bus.pm_out = NPM'(pmv_q[0].neg);
                void'(pmv_q.pop_front());
            end else
                bus.pm_out = 20'h5A5A5;
        end
    end

    // Monitor: tracks enable pulses and sign behaviour, scores results on done.
    int         nw     = 0;
    int         en_run = 0;
    int         gap    = 0;
    int         w_seen [2];
    int         sel_seen = -1;
    logic [1:0] prev_sign = 2'b00;

    always @(negedge clk) begin
        if (!rstb) begin
            nw = 0; en_run = 0; gap = 0; sel_seen = -1; prev_sign = 2'b00;
            w_seen[0] = 0; w_seen[1] = 0;
        end else begin
            if (bus.en_pm) begin
                if (en_run == 0) begin
                    check("sign_before_rise", prev_sign, bus.sel_pm_sign);
                    if (nw == 0) sel_seen = bus.sel_pm_in;
                end
                check("sign_during_meas", bus.sel_pm_sign, (nw == 0) ? PM_SIGN_POS : PM_SIGN_NEG);
                en_run++;
            end else begin
                if (en_run > 0) begin
                    if (nw < 2) w_seen[nw] = en_run;
                    nw++;
                    en_run = 0;
                end
                if (nw == 1) gap++;
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", bus.done, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("pm_pos", bus.pm_pos, e.pos);
                    check("pm_neg", bus.pm_neg, e.neg);
                    check("pm_diff", $signed(bus.pm_diff), e.pos - e.neg);
                    check("en_pulses", nw, 2);
                    check("en_width_p", w_seen[0], e.w);
                    check("en_width_n", w_seen[1], e.w);
                    check("en_gap", gap, 1 + NSET);
                    check("sel_pm_in", sel_seen, e.sel);
                    check("busy_in_done", bus.busy, 1);
                end
                nw = 0; en_run = 0; gap = 0; sel_seen = -1;
                w_seen[0] = 0; w_seen[1] = 0;
            end
            prev_sign = bus.sel_pm_sign;
        end
    end

    // Called on a negedge: the following posedge accepts the run.
    task automatic issue(input int wl, input int sel, input int pos, input int neg,
                         output longint done_cyc);
        exp_t e;
        int   w;
        w              = (wl == 0) ? 1 : wl;
        bus.start      = 1'b1;
        bus.cfg_sel_in = 2'(sel);
        bus.win_len    = NWIN'(wl);
        done_cyc       = cyc + 1 + 2 * (1 + w + NSET);
        e.pos = pos; e.neg = neg; e.w = w; e.sel = sel; e.done_cyc = done_cyc;
        exp_q.push_back(e);
        pmv_q.push_back('{pos: pos, neg: neg});
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (bus.busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) check("idle_timeout", bus.busy, 0);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            pmv_q.delete();
        end
    endtask

    task automatic run_one(input int wl, input int sel, input int pos, input int neg,
                           input bit glitch);
        longint d;
        wait_idle();
        issue(wl, sel, pos, neg, d);
        @(negedge clk);
        bus.start = 1'b0;
        // Inputs wiggle freely while busy, but start must be low when DONE is left.
        while (glitch && cyc < d - 1) begin
            bus.start      = 1'($urandom_range(0, 1));
            bus.cfg_sel_in = 2'($urandom);
            bus.win_len    = NWIN'($urandom_range(0, 20));
            @(negedge clk);
        end
        bus.start = 1'b0;
        drain();
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_en_pm"},       bus.en_pm,       0);
        check({tag, "_sel_pm_sign"}, bus.sel_pm_sign, 0);
        check({tag, "_sel_pm_in"},   bus.sel_pm_in,   0);
        check({tag, "_busy"},        bus.busy,        0);
        check({tag, "_done"},        bus.done,        0);
        check({tag, "_pm_pos"},      bus.pm_pos,      0);
        check({tag, "_pm_neg"},      bus.pm_neg,      0);
        check({tag, "_pm_diff"},     bus.pm_diff,     0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        longint d;
        int     sels [3];
        longint a;

        bus.start      = 1'b0;
        bus.cfg_sel_in = 2'b00;
        bus.win_len    = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rstb = 1'b1;

        run_one(8, 1, 1000, 400, 1'b0);
        run_one(8, 2, 5, 'hFFFFF, 1'b0);
        run_one(0, 3, 77, 66, 1'b0);

        // Reset in the middle of the positive window.
        wait_idle();
        issue(8, 2, 123, 456, d);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_en_pm", bus.en_pm, 1);
        #2 rstb = 1'b0;
        #1 check_all_zero("midrun_reset");
        exp_q.delete();
        pmv_q.delete();
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_busy", bus.busy, 0);
        check("post_reset_en_pm", bus.en_pm, 0);
        check("post_reset_sign", bus.sel_pm_sign, 0);

        for (int i = 0; i < 15; i++)
            run_one($urandom_range(0, 20), $urandom_range(0, 3),
                    $urandom_range(0, (1 << NPM) - 1), $urandom_range(0, (1 << NPM) - 1), 1'b1);

        // Back-to-back runs with start held high; cfg_sel_in changes mid-run.
        wait_idle();
        sels[0] = 1; sels[1] = 2; sels[2] = 3;
        a = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.pos = $urandom_range(0, (1 << NPM) - 1);
            e.neg = $urandom_range(0, (1 << NPM) - 1);
            e.w   = 8;
            e.sel = sels[k];
            e.done_cyc = a + 26 + 27 * k;
            exp_q.push_back(e);
            pmv_q.push_back('{pos: e.pos, neg: e.neg});
        end
        bus.start      = 1'b1;
        bus.cfg_sel_in = 2'(sels[0]);
        bus.win_len    = NWIN'(8);
        for (int k = 1; k < 3; k++) begin
            while (cyc < a + 27 * (k - 1) + 3) @(negedge clk);
            bus.cfg_sel_in = 2'(sels[k]);
        end
        while (cyc < a + 60) @(negedge clk);
        bus.start = 1'b0;
        drain();

        repeat (4) @(negedge clk);
        check("final_idle_busy", bus.busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
